// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module   : y86_pkg
// Purpose  : Shared constants for the Y86-64 memory stage. Holds the icode
//            values, stat codes, memory-operation enum and FSM state codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Status codes
  localparam logic [3:0] SAOK = 4'd1;
  localparam logic [3:0] SHLT = 4'd2;
  localparam logic [3:0] SADR = 4'd3;
  localparam logic [3:0] SINS = 4'd4;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } mem_op_e;

  // Memory-stage FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage : y86_pkg
`default_nettype wire

// File: rtl/mem_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : mem_op_decode
// Purpose  : Combinational decode of the M-stage icode into a memory op,
//            the effective byte address and an address-legality flag.
// Ports    : icode_i  - icode in M
//            val_e_i  - ALU result (address for rmmovq/mrmovq/pushq/call)
//            val_a_i  - address for popq/ret
//            op_o     - OP_NONE / OP_RD / OP_WR
//            addr_o   - selected byte address
//            legal_o  - 1 when the 8-byte access fits inside the memory
// Revision : 1.0 - initial release
// ============================================================================
module mem_op_decode
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192,
  parameter bit          ALIGN_CHK = 1'b0
) (
  input  logic [3:0]  icode_i,
  input  logic [63:0] val_e_i,
  input  logic [63:0] val_a_i,
  output mem_op_e     op_o,
  output logic [63:0] addr_o,
  output logic        legal_o
);

  // Highest address at which a full quad-word still fits. The compare is on
  // all 64 bits, so huge addresses never wrap back into range.
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES) - 64'd8;

  always_comb begin
    op_o   = OP_NONE;
    addr_o = val_e_i;
    case (icode_i)
      IRMMOVQ, ICALL, IPUSHQ: op_o = OP_WR;
      IMRMOVQ:                op_o = OP_RD;
      IPOPQ, IRET: begin
        op_o   = OP_RD;
        addr_o = val_a_i;
      end
      default:                op_o = OP_NONE;
    endcase
  end

  always_comb begin
    legal_o = (addr_o <= LAST_ADDR);
    if (ALIGN_CHK && (addr_o[2:0] != 3'd0)) begin
      legal_o = 1'b0;
    end
  end

endmodule : mem_op_decode
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : Sequences the pipeline memory stage onto a single-port,
//            variable-latency data memory (req/gnt/rvalid), stalls the
//            pipeline until the access completes, range-checks addresses
//            and aborts hung accesses with SADR.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            M_valid/M_icode/M_stat - M-register instruction info
//            M_valE/M_valA          - address / store data
//            m_stall                - hold M and upstream this cycle
//            m_valM/m_stat          - registered read data / final status
//            m_done                 - one-cycle completion pulse
//            mem_req/we/addr/wdata  - request side of the memory port
//            mem_gnt/rvalid/rdata   - response side of the memory port
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned TIMEOUT   = 15,
  parameter bit          ALIGN_CHK = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_valid,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  M_stat,
  input  logic [63:0] M_valE,
  input  logic [63:0] M_valA,
  output logic        m_stall,
  output logic [63:0] m_valM,
  output logic [3:0]  m_stat,
  output logic        m_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  mem_op_e     dec_op;
  logic [63:0] dec_addr;
  logic        dec_legal;
  logic        issue;
  logic [3:0]  timer_inc;

  logic [1:0]  state_q,  state_d;
  logic [3:0]  timer_q,  timer_d;
  logic        req_q,    req_d;
  logic        we_q,     we_d;
  logic [63:0] addr_q,   addr_d;
  logic [63:0] wdata_q,  wdata_d;
  logic [63:0] valm_q,   valm_d;
  logic [3:0]  stat_q,   stat_d;

  mem_op_decode #(
    .MEM_BYTES (MEM_BYTES),
    .ALIGN_CHK (ALIGN_CHK)
  ) u_decode (
    .icode_i (M_icode),
    .val_e_i (M_valE),
    .val_a_i (M_valA),
    .op_o    (dec_op),
    .addr_o  (dec_addr),
    .legal_o (dec_legal)
  );

  assign issue = M_valid && (M_stat == SAOK) && (dec_op != OP_NONE);

  // Saturating increment; the timer is only meaningful inside WAIT.
  assign timer_inc = (timer_q == 4'hF) ? timer_q : (timer_q + 4'd1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valm_d  = valm_q;
    stat_d  = stat_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          if (dec_legal) begin
            // Latch everything the access needs so later M_* changes
            // cannot disturb the request.
            state_d = ST_REQ;
            req_d   = 1'b1;
            we_d    = (dec_op == OP_WR);
            addr_d  = dec_addr;
            wdata_d = M_valA;
          end else begin
            state_d = ST_DONE;
            stat_d  = SADR;
          end
        end else begin
          stat_d = M_stat;
        end
      end
      ST_REQ: begin
        // A simultaneous rvalid is not a response to this request yet.
        if (mem_gnt) begin
          state_d = ST_WAIT;
          req_d   = 1'b0;
          timer_d = 4'd0;
        end
      end
      ST_WAIT: begin
        timer_d = timer_inc;
        if (mem_rvalid) begin
          state_d = ST_DONE;
          stat_d  = SAOK;
          if (!we_q) begin
            valm_d = mem_rdata;
          end
        end else if (timer_inc == TIMEOUT_C) begin
          // Compare the incremented count so the abort follows exactly
          // TIMEOUT cycles spent in WAIT.
          state_d = ST_DONE;
          stat_d  = SADR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= 4'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      valm_q  <= 64'd0;
      stat_q  <= SAOK;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valm_q  <= valm_d;
      stat_q  <= stat_d;
    end
  end

  // Stall already in IDLE when an access starts, so M holds until DONE.
  assign m_stall   = ((state_q == ST_IDLE) && issue) ||
                     (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign m_done    = (state_q == ST_DONE);
  assign m_valM    = valm_q;
  assign m_stat    = stat_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule : mem_stage_ctrl
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Directed self-checking bench for mem_stage_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_valid;
  logic [3:0]  M_icode;
  logic [3:0]  M_stat;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic        m_stall;
  logic [63:0] m_valM;
  logic [3:0]  m_stat;
  logic        m_done;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_stage_ctrl #(
    .MEM_BYTES (8192),
    .TIMEOUT   (15),
    .ALIGN_CHK (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .M_valid    (M_valid),
    .M_icode    (M_icode),
    .M_stat     (M_stat),
    .M_valE     (M_valE),
    .M_valA     (M_valA),
    .m_stall    (m_stall),
    .m_valM     (m_valM),
    .m_stat     (m_stat),
    .m_done     (m_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_m(input logic v, input logic [3:0] ic, input logic [3:0] st,
                       input logic [63:0] ve, input logic [63:0] va);
    M_valid = v; M_icode = ic; M_stat = st; M_valE = ve; M_valA = va;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    set_m(1'b0, 4'h0, 4'd1, 64'd0, 64'd0);
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b want 0", mem_we); end
    checks++; if (mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin errors++; $display("FAIL rst_addr_wdata: got %h/%h want 0/0", mem_addr, mem_wdata); end
    checks++; if (m_stall !== 1'b0 || m_done !== 1'b0) begin errors++; $display("FAIL rst_stall_done: got %0b/%0b want 0/0", m_stall, m_done); end
    checks++; if (m_valM !== 64'd0) begin errors++; $display("FAIL rst_valM: got %h want 0", m_valM); end
    checks++; if (m_stat !== 4'd1) begin errors++; $display("FAIL rst_stat: got %0d want 1", m_stat); end
    rst = 1'b0;
    tick();
  endtask

  // mrmovq, immediate grant, rvalid one cycle later: 3 stalled cycles + DONE.
  task automatic test_read();
    set_m(1'b1, 4'h5, 4'd1, 64'h40, 64'd0);
    #1;
    checks++; if (m_stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL rd_idle: stall/req got %0b/%0b want 1/0", m_stall, mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h40 || m_stall !== 1'b1) begin errors++; $display("FAIL rd_req: req/we/addr/stall got %0b/%0b/%h/%0b want 1/0/40/1", mem_req, mem_we, mem_addr, m_stall); end
    mem_gnt = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b0 || m_stall !== 1'b1 || m_done !== 1'b0) begin errors++; $display("FAIL rd_wait: req/stall/done got %0b/%0b/%0b want 0/1/0", mem_req, m_stall, m_done); end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hDEAD;
    tick();
    checks++; if (m_stall !== 1'b0 || m_done !== 1'b1) begin errors++; $display("FAIL rd_done: stall/done got %0b/%0b want 0/1", m_stall, m_done); end
    checks++; if (m_valM !== 64'hDEAD || m_stat !== 4'd1) begin errors++; $display("FAIL rd_data: valM/stat got %h/%0d want dead/1", m_valM, m_stat); end
    mem_rvalid = 1'b0;
    set_m(1'b0, 4'h1, 4'd1, 64'd0, 64'd0);
    tick();
    checks++; if (m_done !== 1'b0 || m_stall !== 1'b0) begin errors++; $display("FAIL rd_pulse: done/stall got %0b/%0b want 0/0", m_done, m_stall); end
  endtask

  // pushq at the last legal address, grant withheld for 4 REQ cycles.
  task automatic test_write_delayed();
    set_m(1'b1, 4'hA, 4'd1, 64'h1FF8, 64'h5);
    #1;
    checks++; if (m_stall !== 1'b1) begin errors++; $display("FAIL wr_idle_stall: got %0b want 1", m_stall); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h1FF8 || mem_wdata !== 64'h5) begin errors++; $display("FAIL wr_req_hold[%0d]: req/we/addr/wdata got %0b/%0b/%h/%h want 1/1/1ff8/5", i, mem_req, mem_we, mem_addr, mem_wdata); end
      if (i == 4) mem_gnt = 1'b1;
    end
    tick();
    checks++; if (mem_req !== 1'b0 || m_stall !== 1'b1) begin errors++; $display("FAIL wr_wait: req/stall got %0b/%0b want 0/1", mem_req, m_stall); end
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1234;
    tick();
    checks++; if (m_done !== 1'b1 || m_stat !== 4'd1 || m_valM !== 64'hDEAD) begin errors++; $display("FAIL wr_done: done/stat/valM got %0b/%0d/%h want 1/1/dead", m_done, m_stat, m_valM); end
    mem_rvalid = 1'b0;
    set_m(1'b0, 4'h1, 4'd1, 64'd0, 64'd0);
    tick();
  endtask

  // Illegal addresses: one byte past the limit, and a huge value that must not wrap.
  task automatic test_bad_addr();
    logic [3:0]  ics   [2];
    logic [63:0] addrs [2];
    ics[0] = 4'h4; addrs[0] = 64'h1FF9;
    ics[1] = 4'h8; addrs[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    for (int i = 0; i < 2; i++) begin
      set_m(1'b1, ics[i], 4'd1, addrs[i], 64'h77);
      #1;
      checks++; if (m_stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL bad_idle[%0d]: stall/req got %0b/%0b want 1/0", i, m_stall, mem_req); end
      tick();
      checks++; if (mem_req !== 1'b0 || m_done !== 1'b1 || m_stat !== 4'd3 || m_stall !== 1'b0) begin errors++; $display("FAIL bad_done[%0d]: req/done/stat/stall got %0b/%0b/%0d/%0b want 0/1/3/0", i, mem_req, m_done, m_stat, m_stall); end
      set_m(1'b0, 4'h1, 4'd1, 64'd0, 64'd0);
      tick();
    end
  endtask

  // ret at M_valA; grant but never rvalid: abort after 15 WAIT cycles.
  task automatic test_timeout();
    set_m(1'b1, 4'h9, 4'd1, 64'h1_0000_0000, 64'h100);
    tick();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 64'h100) begin errors++; $display("FAIL to_req: req/we/addr got %0b/%0b/%h want 1/0/100", mem_req, mem_we, mem_addr); end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 15; i++) begin
      checks++; if (m_done !== 1'b0 || m_stall !== 1'b1) begin errors++; $display("FAIL to_wait[%0d]: done/stall got %0b/%0b want 0/1", i, m_done, m_stall); end
      tick();
    end
    checks++; if (m_done !== 1'b1 || m_stat !== 4'd3 || m_valM !== 64'hDEAD) begin errors++; $display("FAIL to_abort: done/stat/valM got %0b/%0d/%h want 1/3/dead", m_done, m_stat, m_valM); end
    set_m(1'b0, 4'h1, 4'd1, 64'd0, 64'd0);
    tick();
  endtask

  // Reset in the middle of WAIT; a late rvalid must be dropped.
  task automatic test_reset_mid();
    set_m(1'b1, 4'h5, 4'd1, 64'h80, 64'd0);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; rst = 1'b1;
    set_m(1'b0, 4'h1, 4'd1, 64'd0, 64'd0);
    tick();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hBEEF;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin errors++; $display("FAIL mid_rst_mem: req/we/addr/wdata got %0b/%0b/%h/%h want 0/0/0/0", mem_req, mem_we, mem_addr, mem_wdata); end
    checks++; if (m_stall !== 1'b0 || m_done !== 1'b0 || m_valM !== 64'd0 || m_stat !== 4'd1) begin errors++; $display("FAIL mid_rst_out: stall/done/valM/stat got %0b/%0b/%h/%0d want 0/0/0/1", m_stall, m_done, m_valM, m_stat); end
    tick();
    mem_rvalid = 1'b0;
    checks++; if (m_valM !== 64'd0 || m_done !== 1'b0 || m_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_drop: valM/done/stall got %h/%0b/%0b want 0/0/0", m_valM, m_done, m_stall); end
  endtask

  // Non-memory or non-issuable instructions pass straight through.
  task automatic test_passthrough();
    logic        vs  [4];
    logic [3:0]  ics [4];
    logic [3:0]  sts [4];
    vs[0] = 1'b1; ics[0] = 4'h1; sts[0] = 4'd2;
    vs[1] = 1'b1; ics[1] = 4'h6; sts[1] = 4'd1;
    vs[2] = 1'b1; ics[2] = 4'h5; sts[2] = 4'd4;
    vs[3] = 1'b0; ics[3] = 4'h5; sts[3] = 4'd3;
    for (int i = 0; i < 4; i++) begin
      set_m(vs[i], ics[i], sts[i], 64'h40, 64'h40);
      #1;
      checks++; if (m_stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL pt_comb[%0d]: stall/req got %0b/%0b want 0/0", i, m_stall, mem_req); end
      tick();
      checks++; if (m_stat !== sts[i] || m_done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL pt_stat[%0d]: stat/done/req got %0d/%0b/%0b want %0d/0/0", i, m_stat, m_done, mem_req, sts[i]); end
    end
    set_m(1'b0, 4'h1, 4'd1, 64'd0, 64'd0);
    tick();
  endtask

  // Two reads in a row; the second sees gnt and rvalid together in REQ.
  task automatic test_back_to_back();
    set_m(1'b1, 4'h5, 4'd1, 64'h10, 64'd0);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h1111;
    tick();
    checks++; if (m_valM !== 64'h1111 || m_done !== 1'b1) begin errors++; $display("FAIL b2b_first: valM/done got %h/%0b want 1111/1", m_valM, m_done); end
    mem_rvalid = 1'b0;
    set_m(1'b1, 4'h5, 4'd1, 64'h18, 64'd0);
    tick();
    checks++; if (m_done !== 1'b0 || m_stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_idle: done/stall/req got %0b/%0b/%0b want 0/1/0", m_done, m_stall, mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h18) begin errors++; $display("FAIL b2b_req: req/addr got %0b/%h want 1/18", mem_req, mem_addr); end
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h0BAD;
    tick();
    checks++; if (mem_req !== 1'b0 || m_stall !== 1'b1 || m_done !== 1'b0 || m_valM !== 64'h1111) begin errors++; $display("FAIL b2b_same_cycle: req/stall/done/valM got %0b/%0b/%0b/%h want 0/1/0/1111", mem_req, m_stall, m_done, m_valM); end
    mem_gnt = 1'b0; mem_rdata = 64'h2222;
    tick();
    checks++; if (m_valM !== 64'h2222 || m_done !== 1'b1 || m_stat !== 4'd1) begin errors++; $display("FAIL b2b_second: valM/done/stat got %h/%0b/%0d want 2222/1/1", m_valM, m_done, m_stat); end
    mem_rvalid = 1'b0;
    set_m(1'b0, 4'h1, 4'd1, 64'd0, 64'd0);
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_delayed();
    test_bad_addr();
    test_timeout();
    test_reset_mid();
    test_passthrough();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_stage_ctrl
`default_nettype wire
